// File: rtl/reg_file_host_bridge_pkg.sv
// Shared types for the REG_FILE host bridge: default widths, command opcodes and FSM states.
package reg_file_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    VFY,
    RD,
    RSP
  } state_e;

  function automatic logic op_writes(input op_e op);
    return (op == OP_WRITE) || (op == OP_FILL);
  endfunction

  // READ/WRITE are single-beat: cmd_len is ignored for them.
  function automatic logic op_multi(input op_e op);
    return (op == OP_FILL) || (op == OP_DUMP);
  endfunction

endpackage

// File: rtl/reg_file_host_bridge_if.sv
// Host-side command/response valid-ready port of the REG_FILE host bridge.
interface reg_file_host_bridge_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );
endinterface

// File: rtl/reg_file_host_bridge.sv
// Host command bridge to REG_FILE: READ/WRITE/FILL/DUMP with read-back verify of every write.
module reg_file_host_bridge
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  reg_file_host_bridge_if.slave host,
  output logic                verify_err,
  output logic [ADDR_W-1:0]   reg_read_addr_1,
  input  logic [DATA_W-1:0]   reg_read_data_1,
  output logic [ADDR_W-1:0]   reg_read_addr_2,
  input  logic [DATA_W-1:0]   reg_read_data_2,
  output logic [ADDR_W-1:0]   reg_write_addr,
  output logic [DATA_W-1:0]   reg_write_data,
  output logic                reg_write_cmd
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_start, r_cur, r_cnt, r_len;
  logic [ADDR_W-1:0] w_cur_nxt, w_cnt_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_rd_addr1, r_rd_addr2, r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_last;
  logic              r_verify_err;
  logic              w_accept;
  op_e               w_op;
  logic [ADDR_W:0]   w_beats;

  assign w_op     = op_e'(host.cmd_op);
  assign w_accept = host.cmd_valid && (r_state == IDLE);
  assign w_beats  = {1'b0, r_len} + (ADDR_W + 1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cur_nxt   = host.cmd_addr;
          w_cnt_nxt   = op_multi(w_op) ? host.cmd_len : '0;
          w_state_nxt = op_writes(w_op) ? WR : RD;
        end
      end
      WR:  w_state_nxt = VFY;
      VFY: begin
        if (r_cnt != '0) begin
          w_cur_nxt   = r_cur + 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
          w_state_nxt = WR;
        end else begin
          w_state_nxt = RSP;
        end
      end
      RD:  w_state_nxt = RSP;
      RSP: begin
        if (host.rsp_ready) begin
          if (r_rsp_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_cur_nxt   = r_cur + 1'b1;
            w_cnt_nxt   = r_cnt - 1'b1;
            w_state_nxt = RD;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Port address/data registers are loaded on entry to the state that uses them, so they
  // equal r_cur during that state and otherwise hold their last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_start      <= '0;
      r_cur        <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_wdata      <= '0;
      r_rd_addr1   <= '0;
      r_rd_addr2   <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rsp_addr   <= '0;
      r_rsp_data   <= '0;
      r_rsp_last   <= 1'b0;
      r_verify_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_start <= host.cmd_addr;
        r_len   <= op_multi(w_op) ? host.cmd_len : '0;
        r_wdata <= host.cmd_wdata;
      end
      if (w_state_nxt == WR) begin
        r_wr_addr <= w_cur_nxt;
        r_wr_data <= w_accept ? host.cmd_wdata : r_wdata;
      end
      if (w_state_nxt == VFY) r_rd_addr2 <= w_cur_nxt;
      if (w_state_nxt == RD)  r_rd_addr1 <= w_cur_nxt;
      if ((r_state == VFY) && (reg_read_data_2 != r_wdata)) r_verify_err <= 1'b1;
      if ((r_state == VFY) && (r_cnt == '0)) begin
        r_rsp_addr <= r_start;
        r_rsp_data <= {{(DATA_W - ADDR_W - 1){1'b0}}, w_beats};
        r_rsp_last <= 1'b1;
      end
      if (r_state == RD) begin
        r_rsp_addr <= r_cur;
        r_rsp_data <= reg_read_data_1;
        r_rsp_last <= (r_cnt == '0);
      end
    end
  end

  assign host.cmd_ready = (r_state == IDLE);
  assign host.rsp_valid = (r_state == RSP);
  assign host.rsp_addr  = r_rsp_addr;
  assign host.rsp_data  = r_rsp_data;
  assign host.rsp_last  = r_rsp_last;

  assign verify_err      = r_verify_err;
  assign reg_read_addr_1 = r_rd_addr1;
  assign reg_read_addr_2 = r_rd_addr2;
  assign reg_write_addr  = r_wr_addr;
  assign reg_write_data  = r_wr_data;
  assign reg_write_cmd   = (r_state == WR) && !reset;

endmodule

// File: tb/tb_reg_file_host_bridge.sv
// Self-checking bench for reg_file_host_bridge against a behavioural register-file model.
module tb_reg_file_host_bridge;
  import reg_file_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          verify_err;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] rd1, rd2, wd;
  logic          wcmd;
  logic          corrupt = 1'b0;

  reg_file_host_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) host ();

  reg_file_host_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .host           (host),
    .verify_err     (verify_err),
    .reg_read_addr_1(ra1),
    .reg_read_data_1(rd1),
    .reg_read_addr_2(ra2),
    .reg_read_data_2(rd2),
    .reg_write_addr (wa),
    .reg_write_data (wd),
    .reg_write_cmd  (wcmd)
  );

  always #5 clock = ~clock;

  // Register file stand-in: combinational reads, write on posedge; port 2 optionally corrupted.
  logic [DW-1:0] rf [256];
  initial for (int i = 0; i < 256; i++) rf[i] <= '0;
  always @(posedge clock) if (wcmd) rf[wa] <= wd;
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2] ^ DW'(corrupt);

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [AW-1:0] got_wa[$];
  logic [DW-1:0] got_wd[$];
  always @(negedge clock) if (wcmd) begin
    got_wa.push_back(wa);
    got_wd.push_back(wd);
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          last;
  } rsp_t;

  logic [DW-1:0] mdl [256];
  bit            mdl_verr = 0;
  rsp_t          exp_q[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Command-level model: returns the expected latency of the first response.
  task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [AW-1:0] len, input logic [DW-1:0] d,
                           output int lat);
    int beats;
    logic [AW-1:0] addr;
    rsp_t r;
    beats = (op == OP_READ || op == OP_WRITE) ? 1 : int'(len) + 1;
    for (int i = 0; i < beats; i++) begin
      addr = AW'(int'(a) + i);
      if (op == OP_WRITE || op == OP_FILL) begin
        mdl[addr] = d;
        exp_wa.push_back(addr);
        exp_wd.push_back(d);
        if (corrupt) mdl_verr = 1;
      end else begin
        r.a = addr; r.d = mdl[addr]; r.last = (i == beats - 1);
        exp_q.push_back(r);
      end
    end
    if (op == OP_WRITE || op == OP_FILL) begin
      r.a = a; r.d = DW'(beats); r.last = 1'b1;
      exp_q.push_back(r);
      lat = 2 * beats + 1;
    end else begin
      lat = 2;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] len,
                      input logic [DW-1:0] d, input string tag);
    int w;
    w = 0;
    while (!host.cmd_ready && w < 50) begin tick(); w++; end
    chk({tag, " cmd_ready"}, DW'(host.cmd_ready), 1);
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_addr  = a;
    host.cmd_len   = len;
    host.cmd_wdata = d;
    tick();
    host.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] len,
                        input logic [DW-1:0] d, input int hold, input string tag);
    int lat, w, acc, n;
    bit first;
    rsp_t e;
    exp_q.delete(); exp_wa.delete(); exp_wd.delete();
    got_wa.delete(); got_wd.delete();
    model_cmd(op, a, len, d, lat);
    send(op, a, len, d, tag);
    acc = int'(cyc);
    first = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = 0;
      while (!host.rsp_valid && w < 600) begin tick(); w++; end
      chk({tag, " rsp_valid"}, DW'(host.rsp_valid), 1);
      if (first) chk({tag, " latency"}, DW'(int'(cyc) - acc + 1), DW'(lat));
      first = 0;
      chk({tag, " rsp_addr"}, DW'(host.rsp_addr), DW'(e.a));
      chk({tag, " rsp_data"}, host.rsp_data, e.d);
      chk({tag, " rsp_last"}, DW'(host.rsp_last), DW'(e.last));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({tag, " hold data"}, host.rsp_data, e.d);
        chk({tag, " hold valid/last/ready/addr"},
            DW'({host.rsp_valid, host.rsp_last, host.cmd_ready, host.rsp_addr}),
            DW'({1'b1, e.last, 1'b0, e.a}));
      end
      host.rsp_ready = 1'b1;
      tick();
      host.rsp_ready = 1'b0;
    end
    chk({tag, " idle after"}, DW'({host.cmd_ready, host.rsp_valid}), DW'(2'b10));
    chk({tag, " verify_err"}, DW'(verify_err), DW'(mdl_verr));
    chk({tag, " write count"}, DW'(got_wa.size()), DW'(exp_wa.size()));
    n = (got_wa.size() < exp_wa.size()) ? got_wa.size() : exp_wa.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " write addr"}, DW'(got_wa[i]), DW'(exp_wa[i]));
      chk({tag, " write data"}, got_wd[i], exp_wd[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    host.cmd_valid = 1'b0; host.cmd_op = '0; host.cmd_addr = '0;
    host.cmd_len = '0; host.cmd_wdata = '0; host.rsp_ready = 1'b0;
    void'($urandom(32'h5eed));

    reset = 1'b1;
    tick();
    chk("reset ready/valid/last/verr/wcmd",
        DW'({host.cmd_ready, host.rsp_valid, host.rsp_last, verify_err, wcmd}), DW'(5'b10000));
    chk("reset addr outputs", DW'({ra1, ra2, wa, host.rsp_addr}), '0);
    chk("reset rsp_data", host.rsp_data, '0);
    chk("reset wr_data", wd, '0);
    reset = 1'b0;

    do_cmd(OP_READ,  8'h02, 8'h00, '0, 0, "t1 read02");
    do_cmd(OP_WRITE, 8'h02, 8'h07, 64'hAAAA_AAAA_AAAA_AAAA, 0, "t2 write02");
    do_cmd(OP_READ,  8'h02, 8'h00, '0, 0, "t2 read02");
    do_cmd(OP_FILL,  8'hFE, 8'h03, 64'hBBBB_BBBB_BBBB_BBBB, 0, "t3 fill");
    do_cmd(OP_DUMP,  8'hFE, 8'h03, '0, 0, "t3 dump");
    do_cmd(OP_DUMP,  8'hFC, 8'h05, '0, 5, "t4 dump hold");

    corrupt = 1'b1;
    do_cmd(OP_WRITE, 8'h40, 8'h00, 64'h1234_5678_9ABC_DEF0, 0, "t5 bad write");
    corrupt = 1'b0;
    do_cmd(OP_WRITE, 8'h41, 8'h00, 64'h0F0F_0F0F_0F0F_0F0F, 0, "t5 good write");
    do_cmd(OP_FILL,  8'h42, 8'h02, 64'h5555_0000_5555_0000, 1, "t5 good fill");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl_verr = 0;
    chk("t5 verify_err cleared by reset", DW'(verify_err), 0);

    // Reset lands in the WR cycle of the third FILL beat.
    got_wa.delete(); got_wd.delete();
    send(OP_FILL, 8'h10, 8'h05, 64'hCCCC_CCCC_CCCC_CCCC, "t6 fill");
    tick(); tick(); tick(); tick();
    chk("t6 wcmd before reset", DW'(wcmd), 1);
    reset = 1'b1;
    #1;
    chk("t6 wcmd gated by reset", DW'(wcmd), 0);
    tick();
    reset = 1'b0;
    mdl[8'h10] = 64'hCCCC_CCCC_CCCC_CCCC;
    mdl[8'h11] = 64'hCCCC_CCCC_CCCC_CCCC;
    chk("t6 ready/valid after reset", DW'({host.cmd_ready, host.rsp_valid, verify_err}), DW'(3'b100));
    tick(); tick();
    chk("t6 no response", DW'(host.rsp_valid), 0);
    chk("t6 writes before reset", DW'(got_wa.size()), 2);
    for (int i = 8'h10; i <= 8'h15; i++) chk("t6 reg contents", rf[i], mdl[i]);
    do_cmd(OP_READ, 8'h12, 8'h00, '0, 0, "t6 read12");

    do_cmd(OP_FILL, 8'h80, 8'hFF, 64'hDEAD_BEEF_0000_0001, 0, "full fill");
    do_cmd(OP_DUMP, 8'h80, 8'hFF, '0, 0, "full dump");

    for (int k = 0; k < 40; k++) begin
      logic [1:0]    op;
      logic [AW-1:0] a, len;
      logic [DW-1:0] d;
      op  = 2'($urandom_range(0, 3));
      a   = AW'($urandom);
      len = AW'($urandom_range(0, 7));
      d   = {$urandom, $urandom};
      corrupt = ($urandom_range(0, 9) == 0);
      do_cmd(op, a, len, d, int'($urandom_range(0, 2)), "random");
    end
    corrupt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
